// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 GPR file with write-to-read bypass, hard-wired $zero and overflow write kill
module mips_register_file #(
  parameter logic [31:0] SP_RESET = 32'h0000_3FFC,
  parameter logic [31:0] GP_RESET = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  output logic [31:0] RsData,
  output logic [31:0] RtData,
  input  logic        WrEn,
  input  logic [4:0]  WrAddr,
  input  logic [31:0] WrData,
  input  logic        OvfTrap,
  output logic        TrapOut,
  output logic [15:0] WriteCount
);
  logic [31:0] regs [32];
  logic        commit;
  // Gating on rst keeps the bypass path from leaking write data during reset
  assign commit = WrEn && !OvfTrap && (WrAddr != 5'd0) && !rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 28) ? GP_RESET : (i == 29) ? SP_RESET : 32'h0;
      TrapOut    <= 1'b0;
      WriteCount <= 16'h0;
    end else begin
      if (commit) regs[WrAddr] <= WrData;
      TrapOut    <= WrEn && OvfTrap;
      WriteCount <= WriteCount + {15'h0, commit};
    end
  end
  assign RsData = (RsAddr == 5'd0) ? 32'h0 : (commit && RsAddr == WrAddr) ? WrData : regs[RsAddr];
  assign RtData = (RtAddr == 5'd0) ? 32'h0 : (commit && RtAddr == WrAddr) ? WrData : regs[RtAddr];
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: scoreboard bench for the register file against a behavioural model
module tb_mips_register_file;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RsAddr = '0, RtAddr = '0, WrAddr = '0;
  logic [31:0] RsData, RtData, WrData = '0;
  logic        WrEn = 1'b0, OvfTrap = 1'b0, TrapOut;
  logic [15:0] WriteCount;

  mips_register_file dut (
    .clk(clk), .rst(rst), .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .OvfTrap(OvfTrap), .TrapOut(TrapOut),
    .WriteCount(WriteCount)
  );

  always #5 clk = ~clk;

  typedef struct {string tag; logic [31:0] exp;} sb_t;
  sb_t         sbq[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] mdl [32];
  logic [15:0] mcount;
  logic        ptrap, cm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else begin
      e = sbq.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic expc(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push(tag, exp);
    pop_check(obs);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_3FFC : 32'h0;
    mcount = '0;
    ptrap  = 1'b0;
  endtask

  // Drive one cycle's inputs just after a rising edge and check the combinational view
  task automatic drive(input logic we, input logic ovf, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    WrEn = we; OvfTrap = ovf; WrAddr = wa; WrData = wd; RsAddr = ra; RtAddr = rb;
    cm = we && !ovf && (wa != 5'd0);
    push("rs", (ra == 0) ? 32'h0 : (cm && ra == wa) ? wd : mdl[ra]);
    push("rt", (rb == 0) ? 32'h0 : (cm && rb == wa) ? wd : mdl[rb]);
    push("trap", {31'h0, ptrap});
    push("cnt", {16'h0, mcount});
    #1;
    pop_check(RsData);
    pop_check(RtData);
    pop_check({31'h0, TrapOut});
    pop_check({16'h0, WriteCount});
  endtask

  task automatic step();
    @(posedge clk);
    if (cm) mdl[WrAddr] = WrData;
    mcount = mcount + {15'h0, cm};
    ptrap  = WrEn && OvfTrap;
    #1;
  endtask

  initial begin
    int n;
    mdl_reset();
    cm = 1'b0;
    #13 rst = 1'b1;
    #1 RsAddr = 5'd0; RtAddr = 5'd5;
    #1 expc("rst_r0", 32'h0, RsData);
    expc("rst_r5", 32'h0, RtData);
    RsAddr = 5'd28; RtAddr = 5'd29;
    #1 expc("rst_r28", 32'h0000_1800, RsData);
    expc("rst_r29", 32'h0000_3FFC, RtData);
    expc("rst_trap", 32'h0, {31'h0, TrapOut});
    expc("rst_cnt", 32'h0, {16'h0, WriteCount});
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    drive(1, 0, 8, 32'hDEAD_BEEF, 0, 0); step();
    drive(0, 0, 0, 0, 8, 0);
    expc("r8", 32'hDEAD_BEEF, RsData);
    expc("cnt1", 32'd1, {16'h0, WriteCount});
    step();

    drive(1, 0, 9, 32'h1234_5678, 9, 9);
    expc("byp_rs", 32'h1234_5678, RsData);
    expc("byp_rt", 32'h1234_5678, RtData);
    step();
    drive(0, 0, 0, 0, 9, 9);
    expc("r9", 32'h1234_5678, RsData);
    step();

    drive(1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    expc("zero_byp", 32'h0, RsData);
    step();
    drive(0, 0, 0, 0, 0, 0);
    expc("zero_after", 32'h0, RsData);
    expc("cnt_zero", 32'd2, {16'h0, WriteCount});
    step();

    drive(1, 0, 10, 32'h7FFF_FFFF, 0, 0); step();
    drive(1, 1, 10, 32'h8000_0000, 0, 10);
    expc("ovf_nobyp", 32'h7FFF_FFFF, RtData);
    step();
    drive(0, 0, 0, 0, 0, 10);
    expc("ovf_trap", 32'd1, {31'h0, TrapOut});
    expc("ovf_r10", 32'h7FFF_FFFF, RtData);
    expc("ovf_cnt", 32'd3, {16'h0, WriteCount});
    step();
    drive(0, 0, 0, 0, 0, 0);
    expc("ovf_trap_end", 32'd0, {31'h0, TrapOut});
    step();

    drive(1, 1, 0, 32'h5555_AAAA, 0, 0); step();
    drive(1, 1, 5, 32'h1111_2222, 5, 0);
    expc("trap_r0", 32'd1, {31'h0, TrapOut});
    step();
    drive(0, 0, 0, 0, 5, 0);
    expc("trap_b2b", 32'd1, {31'h0, TrapOut});
    expc("kill_r5", 32'h0, RsData);
    step();
    drive(0, 0, 0, 0, 0, 0);
    expc("trap_b2b_end", 32'd0, {31'h0, TrapOut});
    step();

    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(1)), ($urandom_range(3) == 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      step();
    end

    n = 65536 - int'(mcount);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 5'd1, 32'(i), 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    expc("wrap_cnt", 32'd0, {16'h0, WriteCount});
    step();

    drive(1, 0, 29, 32'hAAAA_5555, 29, 28);
    #2 rst = 1'b1;
    #1 mdl_reset();
    cm = 1'b0;
    expc("midrst_r29", 32'h0000_3FFC, RsData);
    expc("midrst_r28", 32'h0000_1800, RtData);
    expc("midrst_cnt", 32'd0, {16'h0, WriteCount});
    WrEn = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    drive(0, 0, 0, 0, 29, 1);
    expc("post_rst_r29", 32'h0000_3FFC, RsData);
    step();

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
